// File: rtl/seq_mag_comparator_pkg.sv
// Shared types for the sequential magnitude comparator: FSM state encoding,
// one-hot {gt,eq,lt} result encoding and the digit-to-result helper.
package seq_mag_comparator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } cmp_res_t;

   localparam cmp_res_t RES_NONE = 3'b000;
   localparam cmp_res_t RES_GT   = 3'b100;
   localparam cmp_res_t RES_EQ   = 3'b010;
   localparam cmp_res_t RES_LT   = 3'b001;

   // A digit that is neither greater nor less means every digit so far matched.
   function automatic cmp_res_t res_from_digit(input logic d_gt, input logic d_lt);
      if (d_gt) return RES_GT;
      if (d_lt) return RES_LT;
      return RES_EQ;
   endfunction

endpackage

// File: rtl/seq_mag_comparator_if.sv
// Operand/result handshake bundle for seq_mag_comparator.
// master = producer/consumer side, slave = comparator side.
interface seq_mag_comparator_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2
);
   localparam int unsigned CW = $clog2(WIDTH / DIGIT + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signed_mode;
   logic             out_valid;
   logic             out_ready;
   logic             gt;
   logic             eq;
   logic             lt;
   logic [CW-1:0]    cycles;

   modport master (
      output in_valid, a, b, signed_mode, out_ready,
      input  in_ready, out_valid, gt, eq, lt, cycles
   );

   modport slave (
      input  in_valid, a, b, signed_mode, out_ready,
      output in_ready, out_valid, gt, eq, lt, cycles
   );

endinterface

// File: rtl/seq_mag_comparator_digit.sv
// Combinational compare of one DIGIT-bit slice pair.
module seq_mag_comparator_digit #(
   parameter int unsigned DIGIT = 2
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   output logic             d_gt,
   output logic             d_lt
);

   assign d_gt = (x > y);
   assign d_lt = (x < y);

endmodule

// File: rtl/seq_mag_comparator.sv
// Handshaked magnitude comparator: walks the operands DIGIT bits per cycle from
// the MSB and stops at the first differing digit. Signed mode biases the MSBs.
module seq_mag_comparator
   import seq_mag_comparator_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seq_mag_comparator_if.slave  bus
);

   localparam int unsigned N  = WIDTH / DIGIT;
   localparam int unsigned CW = $clog2(N + 1);
   localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("seq_mag_comparator: WIDTH must be >= 2 and divisible by DIGIT");
   end

   state_e           state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   cmp_res_t         res_q, res_d;
   logic [CW-1:0]    cycles_q, cycles_d;
   logic [CW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;

   logic             d_gt;
   logic             d_lt;
   logic             last_digit;
   logic [WIDTH-1:0] sign_flip;

   // Operand regs shift left each RUN cycle, so the current digit is always the top slice.
   seq_mag_comparator_digit #(.DIGIT(DIGIT)) u_digit (
      .x    (a_q[WIDTH-1 -: DIGIT]),
      .y    (b_q[WIDTH-1 -: DIGIT]),
      .d_gt (d_gt),
      .d_lt (d_lt)
   );

   assign last_digit = (k_q == CW'(N - 1));
   assign sign_flip  = bus.signed_mode ? MSB_MASK : '0;

   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      res_d       = res_q;
      cycles_d    = cycles_q;
      k_d         = k_q;
      a_d         = a_q;
      b_d         = b_q;

      unique case (state_q)
         ST_IDLE: begin
            in_ready_d = 1'b1;
            if (bus.in_valid && in_ready_q) begin
               a_d        = bus.a ^ sign_flip;
               b_d        = bus.b ^ sign_flip;
               k_d        = '0;
               in_ready_d = 1'b0;
               state_d    = ST_RUN;
            end
         end
         ST_RUN: begin
            if (d_gt || d_lt || last_digit) begin
               res_d       = res_from_digit(d_gt, d_lt);
               cycles_d    = k_q + CW'(1);
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               a_d = a_q << DIGIT;
               b_d = b_q << DIGIT;
               k_d = k_q + CW'(1);
            end
         end
         ST_DONE: begin
            // Re-open input on the handshake edge so the following IDLE cycle can accept.
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         res_q       <= RES_NONE;
         cycles_q    <= '0;
         k_q         <= '0;
         a_q         <= '0;
         b_q         <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         cycles_q    <= cycles_d;
         k_q         <= k_d;
         a_q         <= a_d;
         b_q         <= b_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.gt        = res_q.gt;
   assign bus.eq        = res_q.eq;
   assign bus.lt        = res_q.lt;
   assign bus.cycles    = cycles_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed and randomised checks of seq_mag_comparator at WIDTH/DIGIT = 8/2, 16/4 and 8/1.
module tb_seq_mag_comparator;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   seq_mag_comparator_if #(.WIDTH(8), .DIGIT(2)) mif ();

   seq_mag_comparator #(.WIDTH(8), .DIGIT(2)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (mif.slave)
   );

   // Sweep instances: index 0 = 16/4, index 1 = 8/1, driven through flat tb-side vectors.
   logic [1:0]       sw_in_valid;
   logic [1:0][15:0] sw_a;
   logic [1:0][15:0] sw_b;
   logic [1:0]       sw_s;
   logic [1:0]       sw_out_ready;
   wire  [1:0]       sw_in_ready;
   wire  [1:0]       sw_out_valid;
   wire  [1:0][2:0]  sw_res;
   wire  [1:0][7:0]  sw_cyc;

   for (genvar g = 0; g < 2; g++) begin : g_sweep
      localparam int unsigned W = (g == 0) ? 16 : 8;
      localparam int unsigned D = (g == 0) ? 4 : 1;

      seq_mag_comparator_if #(.WIDTH(W), .DIGIT(D)) sif ();

      seq_mag_comparator #(.WIDTH(W), .DIGIT(D)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (sif.slave)
      );

      assign sif.in_valid    = sw_in_valid[g];
      assign sif.a           = sw_a[g][W-1:0];
      assign sif.b           = sw_b[g][W-1:0];
      assign sif.signed_mode = sw_s[g];
      assign sif.out_ready   = sw_out_ready[g];
      assign sw_in_ready[g]  = sif.in_ready;
      assign sw_out_valid[g] = sif.out_valid;
      assign sw_res[g]       = {sif.gt, sif.eq, sif.lt};
      assign sw_cyc[g]       = 8'(sif.cycles);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; one transaction on the 8/2 instance, result held `hold` cycles.
   task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [2:0] exp_res, input int exp_cyc,
                          input int hold);
      int lat;
      check({tag, "_inrdy"}, 32'(mif.in_ready), 32'd1);
      mif.a           = a;
      mif.b           = b;
      mif.signed_mode = s;
      mif.in_valid    = 1'b1;
      @(negedge clk);
      mif.in_valid    = 1'b0;
      mif.a           = ~a;
      mif.b           = 8'h00;
      mif.signed_mode = ~s;
      check({tag, "_busy"}, 32'(mif.in_ready), 32'd0);
      lat = 0;
      while (!mif.out_valid && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_cyc));
      check({tag, "_res"}, 32'({mif.gt, mif.eq, mif.lt}), 32'(exp_res));
      check({tag, "_cyc"}, 32'(mif.cycles), 32'(exp_cyc));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_vld"}, 32'(mif.out_valid), 32'd1);
         check({tag, "_hold_res"}, 32'({mif.gt, mif.eq, mif.lt}), 32'(exp_res));
         check({tag, "_hold_cyc"}, 32'(mif.cycles), 32'(exp_cyc));
         check({tag, "_hold_rdy"}, 32'(mif.in_ready), 32'd0);
      end
      mif.out_ready = 1'b1;
      @(negedge clk);
      mif.out_ready = 1'b0;
      check({tag, "_post_vld"}, 32'(mif.out_valid), 32'd0);
      check({tag, "_post_rdy"}, 32'(mif.in_ready), 32'd1);
   endtask

   // Random pairs against an independent reference (integer compare, xor digit scan).
   task automatic sweep(input int g, input int w, input int d, input int iters);
      int          n, lat, ek, ec, sa, sb;
      int unsigned ra, rb, mask, dm;
      logic        s;
      logic [2:0]  er;
      n    = w / d;
      mask = (32'd1 << w) - 1;
      dm   = (32'd1 << d) - 1;
      for (int it = 0; it < iters; it++) begin
         ra = $urandom & mask;
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ (32'd1 << $urandom_range(0, w - 1));
            default: rb = $urandom & mask;
         endcase
         s  = 1'($urandom_range(0, 1));
         sa = ((ra >> (w - 1)) & 1) != 0 ? int'(ra) - (1 << w) : int'(ra);
         sb = ((rb >> (w - 1)) & 1) != 0 ? int'(rb) - (1 << w) : int'(rb);
         er = s ? {sa > sb, sa == sb, sa < sb} : {ra > rb, ra == rb, ra < rb};
         ek = -1;
         for (int k = 0; k < n; k++)
            if (ek < 0 && (((ra ^ rb) >> (w - d * (k + 1))) & dm) != 0) ek = k;
         ec = (ek < 0) ? n : ek + 1;

         check($sformatf("sw%0d_inrdy", g), 32'(sw_in_ready[g]), 32'd1);
         sw_a[g]        = 16'(ra);
         sw_b[g]        = 16'(rb);
         sw_s[g]        = s;
         sw_in_valid[g] = 1'b1;
         @(negedge clk);
         sw_in_valid[g] = 1'b0;
         lat = 0;
         while (!sw_out_valid[g] && lat < n + 4) begin
            @(negedge clk);
            lat++;
         end
         check($sformatf("sw%0d_lat a=%0h b=%0h s=%0b", g, ra, rb, s), 32'(lat), 32'(ec));
         check($sformatf("sw%0d_res a=%0h b=%0h s=%0b", g, ra, rb, s), 32'(sw_res[g]), 32'(er));
         check($sformatf("sw%0d_cyc a=%0h b=%0h s=%0b", g, ra, rb, s), 32'(sw_cyc[g]), 32'(ec));
         sw_out_ready[g] = 1'b1;
         @(negedge clk);
         sw_out_ready[g] = 1'b0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rdy"}, 32'(mif.in_ready), 32'd0);
      check({tag, "_vld"}, 32'(mif.out_valid), 32'd0);
      check({tag, "_res"}, 32'({mif.gt, mif.eq, mif.lt}), 32'd0);
      check({tag, "_cyc"}, 32'(mif.cycles), 32'd0);
   endtask

   initial begin
      n_checks        = 0;
      n_errors        = 0;
      rst_n           = 1'b0;
      mif.in_valid    = 1'b0;
      mif.a           = 8'h00;
      mif.b           = 8'h00;
      mif.signed_mode = 1'b0;
      mif.out_ready   = 1'b0;
      sw_in_valid     = '0;
      sw_a            = '0;
      sw_b            = '0;
      sw_s            = '0;
      sw_out_ready    = '0;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      #1 check("rel_rdy_before_edge", 32'(mif.in_ready), 32'd0);
      @(negedge clk);
      check("rel_rdy_after_edge", 32'(mif.in_ready), 32'd1);

      // Directed vectors, expectations worked by hand.
      run_cmp("t1_u_a5_25", 8'hA5, 8'h25, 1'b0, 3'b100, 1, 0);
      run_cmp("t2_u_5a_5a", 8'h5A, 8'h5A, 1'b0, 3'b010, 4, 0);
      run_cmp("t3_u_13_12", 8'h13, 8'h12, 1'b0, 3'b100, 4, 0);
      run_cmp("t3_s_13_12", 8'h13, 8'h12, 1'b1, 3'b100, 4, 0);
      run_cmp("t3_s_80_7f", 8'h80, 8'h7F, 1'b1, 3'b001, 1, 0);
      run_cmp("t3_u_80_7f", 8'h80, 8'h7F, 1'b0, 3'b100, 1, 0);
      run_cmp("t3_s_ff_01", 8'hFF, 8'h01, 1'b1, 3'b001, 1, 0);
      run_cmp("t4_bp_01_02", 8'h01, 8'h02, 1'b0, 3'b001, 4, 5);

      // Reset during the second RUN cycle of an all-equal compare.
      check("t5_inrdy", 32'(mif.in_ready), 32'd1);
      mif.a        = 8'h00;
      mif.b        = 8'h00;
      mif.in_valid = 1'b1;
      @(negedge clk);
      mif.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1 check_all_zero("t5_async");
      @(negedge clk);
      check_all_zero("t5_held");
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_rdy_back", 32'(mif.in_ready), 32'd1);
      check("t5_no_stale", 32'(mif.out_valid), 32'd0);
      repeat (6) begin
         @(negedge clk);
         check("t5_no_stale_later", 32'(mif.out_valid), 32'd0);
      end
      run_cmp("t5_after_c3_c3", 8'hC3, 8'hC3, 1'b1, 3'b010, 4, 0);

      sweep(0, 16, 4, 1000);
      sweep(1, 8, 1, 1000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
